// File: rtl/cdc_reqqueue.sv
// cdc_reqqueue: buffers request pulses while a downstream request/ack
// synchronizer is busy, then replays them one crossing at a time.
//
// Ports:
//   clk           write-domain clock of the synchronizer being fed
//   rst           asynchronous active-high reset
//   req_in        request pulse; each high cycle is one request
//   busy_in       synchronizer busy flag (crossing in flight)
//   clr_overflow  synchronous clear of the sticky overflow flag
//   req_out       registered one-cycle request to the synchronizer
//   pending       queued requests not yet issued
//   overflow      sticky: a request was dropped on a full queue
//   idle          state is IDLE and nothing is pending
module cdc_reqqueue #(
  parameter int CNT_WIDTH = 4,
  parameter int MIN_GAP   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_in,
  input  logic                 busy_in,
  input  logic                 clr_overflow,
  output logic                 req_out,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow,
  output logic                 idle
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]           GAP_LAST = 4'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Crossing sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      wait_cnt <= '0;
      req_out  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= gap_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      // Registered copy of "in ISSUE" so the synchronizer sees a clean pulse.
      req_out  <= (state_nxt == ISSUE);
    end
  end

  always_comb begin
    state_nxt    = state;
    gap_cnt_nxt  = gap_cnt;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (pending != '0 && !busy_in) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt    = WAIT_BUSY;
        wait_cnt_nxt = '0;
      end
      WAIT_BUSY: begin
        if (busy_in) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == 2'd3) begin
          // Busy never showed up: the crossing completed (or was absorbed)
          // faster than we could observe it.
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!busy_in) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end
      end
      GAP: begin
        // Any busy blip restarts the quiet period from scratch.
        if (busy_in) begin
          gap_cnt_nxt = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending counter and overflow flag
  // ---------------------------------------------------------------------------
  logic dec, inc, ovf_set;

  always_comb begin
    dec = (state == ISSUE) && (pending != '0);
    // A full queue still accepts a request when an issue frees a slot.
    inc     = req_in && ((pending != CNT_MAX) || dec);
    ovf_set = req_in && (pending == CNT_MAX) && !dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (inc && !dec)      pending <= pending + 1'b1;
      else if (dec && !inc) pending <= pending - 1'b1;
      // A new drop wins over a simultaneous clear.
      overflow <= (overflow && !clr_overflow) || ovf_set;
    end
  end

  assign idle = (state == IDLE) && (pending == '0);

endmodule

// File: tb/tb_cdc_reqqueue.sv
module tb_cdc_reqqueue;
  localparam int CW      = 4;
  localparam int MIN_GAP = 2;
  localparam int QMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_in, busy_in, clr_overflow;
  logic          req_out, overflow, idle;
  logic [CW-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  cdc_reqqueue #(.CNT_WIDTH(CW), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .busy_in(busy_in),
    .clr_overflow(clr_overflow), .req_out(req_out), .pending(pending),
    .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue depth plus a description of where we are in the
  // life of one crossing (just issued / waiting for busy / in flight / quiet).
  int m_pend, m_lo_run, m_gap_left;
  bit m_ovf, m_issuing, m_after, m_cross, m_gap;

  function automatic void model_reset();
    m_pend = 0; m_ovf = 0; m_issuing = 0; m_after = 0; m_cross = 0;
    m_gap = 0; m_lo_run = 0; m_gap_left = 0;
  endfunction

  function automatic void model_step(bit r, bit b, bit c);
    bit freed = m_issuing;
    bit drop  = 0;
    int p     = m_pend;
    if (r && !freed) begin
      if (p == QMAX) drop = 1; else m_pend = p + 1;
    end else if (freed && !r) begin
      m_pend = p - 1;
    end
    m_ovf = (m_ovf && !c) || drop;
    if (m_issuing) begin
      m_issuing = 0; m_after = 1; m_lo_run = 0;
    end else if (m_after) begin
      if (b) begin
        m_after = 0; m_cross = 1;
      end else begin
        m_lo_run++;
        if (m_lo_run == 4) begin m_after = 0; m_gap = 1; m_gap_left = MIN_GAP; end
      end
    end else if (m_cross) begin
      if (!b) begin m_cross = 0; m_gap = 1; m_gap_left = MIN_GAP; end
    end else if (m_gap) begin
      if (b) m_gap_left = MIN_GAP;
      else begin
        m_gap_left--;
        if (m_gap_left == 0) m_gap = 0;
      end
    end else if (p > 0 && !b) begin
      m_issuing = 1;
    end
  endfunction

  function automatic bit m_idle();
    return !m_issuing && !m_after && !m_cross && !m_gap && m_pend == 0;
  endfunction

  task automatic compare_all();
    chk("pending",  int'(pending),  m_pend);
    chk("req_out",  int'(req_out),  int'(m_issuing));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("idle",     int'(idle),     int'(m_idle()));
  endtask

  // Inputs are changed just after the falling edge, outputs checked there.
  task automatic step(input bit r, input bit b, input bit c);
    req_in = r; busy_in = b; clr_overflow = c;
    @(posedge clk);
    model_step(r, b, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = 0; busy_in = 0; clr_overflow = 0;
    #1;
    model_reset();
    // Reset must take effect without waiting for a clock edge.
    chk("rst_async_pending", int'(pending), 0);
    chk("rst_async_idle",    int'(idle),    1);
    chk("rst_async_req_out", int'(req_out), 0);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    int n, cnt, busy_run;
    bit bl;
    rst = 1'b1; req_in = 0; busy_in = 0; clr_overflow = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Single pulse: request appears on req_out two cycles later.
    step(1, 0, 0);
    chk("lat_first_cycle", int'(req_out), 0);
    step(0, 0, 0);
    chk("lat_req_out", int'(req_out), 1);
    chk("lat_pending", int'(pending), 1);
    step(0, 1, 0);
    chk("lat_pending_after", int'(pending), 0);
    for (int i = 0; i < 8; i++) step(0, (i < 2), 0);
    chk("single_idle_back", int'(idle), 1);

    // Burst while busy, replayed one per busy-low window.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    chk("burst_pending", int'(pending), 5);
    chk("burst_no_req",  int'(req_out), 0);
    cnt = 0;
    for (int w = 0; w < 7; w++) begin
      for (int i = 0; i < MIN_GAP + 4; i++) begin step(0, 0, 0); cnt += int'(req_out); end
      for (int i = 0; i < 3; i++)           begin step(0, 1, 0); cnt += int'(req_out); end
    end
    chk("burst_total_issues", cnt, 5);
    chk("burst_drained", int'(pending), 0);

    // Saturation, clear, and full-with-issue.
    do_reset();
    for (int i = 0; i < QMAX + 1; i++) step(1, 1, 0);
    chk("sat_pending",  int'(pending),  QMAX);
    chk("sat_overflow", int'(overflow), 1);
    step(1, 1, 1);
    chk("clr_vs_set_overflow", int'(overflow), 1);
    step(0, 1, 1);
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_pending",  int'(pending),  QMAX);
    step(0, 0, 0);
    chk("full_issue_req_out", int'(req_out), 1);
    // Request during the ISSUE cycle, then no busy at all (timeout path).
    n = 0;
    step(1, 0, 0); n++;
    chk("full_issue_pending",  int'(pending),  QMAX);
    chk("full_issue_overflow", int'(overflow), 0);
    while (!req_out && n < 30) begin step(0, 0, 0); n++; end
    chk("timeout_period", n, 6 + MIN_GAP);

    // Reset in the middle of a crossing.
    do_reset();
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 1, 0); step(0, 1, 0);
    chk("mid_pending", int'(pending), 3);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(0, (i % 5) == 1, 0); cnt += int'(req_out); end
    chk("post_reset_no_issue", cnt, 0);
    step(1, 0, 0);
    chk("post_reset_first_req", int'(pending), 1);

    // Randomized traffic against the model.
    busy_run = 0; bl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy_run == 0) begin
        bl = ~bl;
        busy_run = bl ? $urandom_range(1, 8) : $urandom_range(1, 10);
      end
      busy_run--;
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 25), bl,
                $urandom_range(0, 99) < 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
